// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch widths, fetch state enum, queue entry type and address helpers
package cpu_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 256;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    localparam int MEM_AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // True when the word address lies inside the populated memory.
    function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc);
        return (pc >> MEM_AW) == {ADDR_W{1'b0}};
    endfunction

    // Word address folded into the memory, upper bits zeroed.
    function automatic logic [ADDR_W-1:0] mem_index(input logic [ADDR_W-1:0] pc);
        return pc & ADDR_W'(MEM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry fetch FIFO (flush over push), head in slot0, invalid slots held at zero
module fetch_queue
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = slot0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty) begin
                        slot0 <= push_entry;
                    end else begin
                        slot1 <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    slot1 <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with one entry the new word simply replaces the head.
                    if (full) begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end else begin
                        slot0 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer: PC, RUN/HALT/FAULT FSM, 2-entry queue; bounds fault under FETCH_BOUNDS_CHECK_EN
module imem_fetch_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;

    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [1:0]        q_count;
    fetch_entry_t      q_in;
    fetch_entry_t      q_head;

    logic              issue_slot;
    logic              addr_bad;

    assign imem_en = !rst;

    assign out_valid = !q_empty;
    assign out_instr = (q_count != 2'd0) ? q_head.instr : '0;
    assign out_pc    = (q_count != 2'd0) ? q_head.pc    : '0;
    assign q_pop     = out_valid && out_ready;

    // A fetch slot exists in RUN when there is room now or the head leaves this cycle.
    assign issue_slot = (state == RUN) && !halt && !redirect_valid && (!q_full || q_pop);

`ifdef FETCH_BOUNDS_CHECK_EN
    assign addr_bad  = !pc_in_range(pc);
    assign imem_addr = pc;
`else
    assign addr_bad  = 1'b0;
    assign imem_addr = mem_index(pc);
`endif

    assign q_push = issue_slot && !addr_bad;
    assign q_in   = '{instr: imem_rdata, pc: pc};

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (q_in),
        .pop        (q_pop),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            state_nxt = halt ? HALT : RUN;
            pc_nxt    = redirect_pc;
        end else begin
            case (state)
                RUN: begin
                    if (q_push) begin
                        pc_nxt = pc + ADDR_W'(1);
                    end
                    if (issue_slot && addr_bad) begin
                        state_nxt = FAULT;
                    end else if (halt) begin
                        state_nxt = HALT;
                    end
                end
                HALT: begin
                    if (!halt) begin
                        state_nxt = RUN;
                    end
                end
`ifdef FETCH_BOUNDS_CHECK_EN
                FAULT: begin
                    state_nxt = FAULT;
                end
`endif
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] fault_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pc_q <= '0;
        end else if (redirect_valid) begin
            fault_pc_q <= '0;
        end else if (issue_slot && addr_bad) begin
            fault_pc_q <= pc;
        end
    end

    assign fault    = (state == FAULT);
    assign fault_pc = fault_pc_q;
`else
    assign fault    = 1'b0;
    assign fault_pc = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scenario tasks plus randomized traffic checked against a queue-based fetch model
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
    import cpu_pkg::*;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready = 1'b0;
    logic              fault;
    logic [ADDR_W-1:0] fault_pc;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_pc;
    bit          m_halted;
    bit          m_faulted;
    int unsigned m_fault_pc;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < MEM_DEPTH) ? mem[imem_addr[MEM_AW-1:0]] : 16'hDEAD;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    function automatic void model_reset();
        mq.delete();
        m_pc       = 32'(RESET_PC);
        m_halted   = 1'b0;
        m_faulted  = 1'b0;
        m_fault_pc = 0;
    endfunction

    // One clock of fetch behaviour, evaluated from the inputs held during the cycle.
    function automatic void model_step();
        bit pop;
        bit issue;
        pop   = (mq.size() != 0) && out_ready;
        issue = 1'b0;
        if (redirect_valid) begin
            mq.delete();
            m_pc       = 32'(redirect_pc);
            m_faulted  = 1'b0;
            m_fault_pc = 0;
            m_halted   = halt;
            return;
        end
        if (!m_halted && !m_faulted && !halt && (mq.size() < 2 || pop)) issue = 1'b1;
        if (pop) void'(mq.pop_front());
        if (issue) begin
            if (BOUNDS && m_pc >= MEM_DEPTH) begin
                m_faulted  = 1'b1;
                m_fault_pc = m_pc;
            end else begin
                mq.push_back('{instr: mem[m_pc % MEM_DEPTH], pc: 16'(m_pc)});
                m_pc = (m_pc + 1) % 65536;
            end
        end
        if (!m_faulted) m_halted = halt;
    endfunction

    function automatic logic        exp_valid(); return mq.size() != 0; endfunction
    function automatic logic [15:0] exp_pc();    return (mq.size() != 0) ? mq[0].pc : 16'h0; endfunction
    function automatic logic [15:0] exp_instr(); return (mq.size() != 0) ? mq[0].instr : 16'h0; endfunction
    function automatic logic [15:0] exp_addr();  return 16'(BOUNDS ? m_pc : m_pc % MEM_DEPTH); endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 16'h1000 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL reset_imem_en: got %b want 0", imem_en); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_instr !== 16'h0 || out_pc !== 16'h0) begin n_bad++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_instr, out_pc); end
        n_cmp++; if (fault !== 1'b0 || fault_pc !== 16'h0) begin n_bad++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
        n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h want %h", imem_addr, RESET_PC); end
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (imem_en !== 1'b1) begin n_bad++; $display("FAIL release_imem_en: got %b want 1", imem_en); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'(k)) begin n_bad++; $display("FAIL stream_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, 16'(k)); end
            n_cmp++; if (out_instr !== 16'h1000 + 16'(k)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", out_instr, 16'h1000 + 16'(k)); end
            n_cmp++; if (imem_addr !== 16'(k + 1)) begin n_bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, 16'(k + 1)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (out_instr !== 16'h1000 || out_pc !== 16'h0) begin n_bad++; $display("FAIL bp_hold: got %h/%h want 1000/0000", out_instr, out_pc); end
        end
        n_cmp++; if (imem_addr !== 16'd2) begin n_bad++; $display("FAIL bp_pc_frozen: got %h want 0002", imem_addr); end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'(j) || out_instr !== 16'h1000 + 16'(j)) begin
                n_bad++; $display("FAIL bp_order: got v=%b pc=%h instr=%h want pc=%h", out_valid, out_pc, out_instr, 16'(j));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b1;
        repeat (5) tick();
        n_cmp++; if (imem_addr !== 16'd5 || out_valid !== 1'b1) begin n_bad++; $display("FAIL redir_setup: got addr=%h v=%b want 0005/1", imem_addr, out_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
        n_cmp++; if (imem_addr !== 16'h0040) begin n_bad++; $display("FAIL redir_pc: got %h want 0040", imem_addr); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== 16'h1040) begin
            n_bad++; $display("FAIL redir_target: got v=%b pc=%h instr=%h want 1/0040/1040", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_halt();
        bit seen;
        do_reset();
        out_ready = 1'b0;
        repeat (2) tick();
        halt      = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'd1) begin n_bad++; $display("FAIL halt_drain1: got v=%b pc=%h want 1/0001", out_valid, out_pc); end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 16'd2) begin n_bad++; $display("FAIL halt_idle: got v=%b addr=%h want 0/0002", out_valid, imem_addr); end
            tick();
        end
        halt = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            tick();
            seen = out_valid;
        end
        n_cmp++; if (!seen || out_pc !== 16'd2 || out_instr !== 16'h1002) begin n_bad++; $display("FAIL halt_resume: got v=%b pc=%h instr=%h want 1/0002/1002", seen, out_pc, out_instr); end
    endtask

    task automatic test_bounds();
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd255;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'd255 || out_instr !== 16'h10FF) begin n_bad++; $display("FAIL bounds_last: got v=%b pc=%h instr=%h want 1/00ff/10ff", out_valid, out_pc, out_instr); end
        n_cmp++; if (imem_addr !== (BOUNDS ? 16'd256 : 16'd0)) begin n_bad++; $display("FAIL bounds_addr: got %h want %h", imem_addr, BOUNDS ? 16'd256 : 16'd0); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (fault !== BOUNDS || fault_pc !== (BOUNDS ? 16'd256 : 16'd0)) begin n_bad++; $display("FAIL bounds_fault: got %b/%h want %b/%h", fault, fault_pc, BOUNDS, BOUNDS ? 16'd256 : 16'd0); end
            n_cmp++; if (out_valid !== exp_valid() || out_pc !== exp_pc()) begin n_bad++; $display("FAIL bounds_queue: got v=%b pc=%h want v=%b pc=%h", out_valid, out_pc, exp_valid(), exp_pc()); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'd0;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (fault !== 1'b0 || fault_pc !== 16'd0) begin n_bad++; $display("FAIL bounds_clear: got %b/%h want 0/0000", fault, fault_pc); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'd0) begin n_bad++; $display("FAIL bounds_restart: got v=%b pc=%h want 1/0000", out_valid, out_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_instr !== 16'h0 || out_pc !== 16'h0) begin n_bad++; $display("FAIL midrst_out: got v=%b %h/%h want 0/0/0", out_valid, out_instr, out_pc); end
        n_cmp++; if (imem_addr !== RESET_PC || imem_en !== 1'b0) begin n_bad++; $display("FAIL midrst_pc: got addr=%h en=%b want %h/0", imem_addr, imem_en, RESET_PC); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin n_bad++; $display("FAIL midrst_restart: got v=%b pc=%h want 1/%h", out_valid, out_pc, RESET_PC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int c = 0; c < 600; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 11) == 0) halt = !halt;
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(250, 259)) : 16'($urandom_range(0, 300));
            tick();
            n_cmp++; if (out_valid !== exp_valid()) begin n_bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, exp_valid()); end
            n_cmp++; if (out_pc !== exp_pc() || out_instr !== exp_instr()) begin n_bad++; $display("FAIL rnd_head c=%0d: got %h/%h want %h/%h", c, out_pc, out_instr, exp_pc(), exp_instr()); end
            n_cmp++; if (imem_addr !== exp_addr()) begin n_bad++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_addr, exp_addr()); end
            n_cmp++; if (fault !== m_faulted || fault_pc !== 16'(m_fault_pc)) begin n_bad++; $display("FAIL rnd_fault c=%0d: got %b/%h want %b/%h", c, fault, fault_pc, m_faulted, 16'(m_fault_pc)); end
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_bounds();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
